// File: rtl/bt_uart_pkg.sv
// Shared types and constants for the Bluetooth UART transmitter.
package bt_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int unsigned DATA_BITS      = 8;
  localparam int unsigned FRAME_BITS_8N1 = 10;
  localparam int unsigned FRAME_BITS_8E1 = 11;

  // Clock cycles per bit; truncating division.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/bt_tx_fifo.sv
// Synchronous byte FIFO with registered count; read data is first-word fall-through.
module bt_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/bt_uart_tx.sv
// UART transmitter (8N1, or 8E1 when BT_UART_TX_PARITY_EN is defined) fed by a byte FIFO.
// FSM, baud counter, shift register and registered tx pin live here.
import bt_uart_pkg::*;

module bt_uart_tx #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       idx_q, idx_d;
  logic             tx_q, tx_d;
`ifdef BT_UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  logic                       push_c;
  logic                       pop_c;
  logic                       wrap_c;
  logic [7:0]                 fifo_rdata;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign push_c = tx_valid && tx_ready;

  bt_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .wdata (tx_data),
    .pop   (pop_c),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-state logic; every bit boundary coincides with a counter wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    pop_c   = 1'b0;
`ifdef BT_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    wrap_c  = (cnt_q == CNT_MAX);

    if (state_q != ST_IDLE) begin
      cnt_d = wrap_c ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shift_d = fifo_rdata;
          idx_d   = '0;
          state_d = ST_START;
          tx_d    = 1'b0;
`ifdef BT_UART_TX_PARITY_EN
          par_d   = ^fifo_rdata;
`endif
        end
      end
      ST_START: begin
        if (wrap_c) begin
          state_d = ST_DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (wrap_c) begin
          if (idx_q == LAST_BIT) begin
`ifdef BT_UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = par_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef BT_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (wrap_c) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (wrap_c) begin
          // Chain straight into the next start bit when a byte is waiting.
          if (!fifo_empty) begin
            pop_c   = 1'b1;
            shift_d = fifo_rdata;
            idx_d   = '0;
            state_d = ST_START;
            tx_d    = 1'b0;
`ifdef BT_UART_TX_PARITY_EN
            par_d   = ^fifo_rdata;
`endif
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
`ifdef BT_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
`ifdef BT_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign tx_ready = !fifo_full;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;

  a_empty_matches_count: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_empty == (fifo_count == '0));

endmodule

// File: tb/tb_bt_uart_tx.sv
// Scoreboard bench for bt_uart_tx at DIV=16: stimulus queues expected frames, a line monitor decodes tx.
module tb_bt_uart_tx;
  import bt_uart_pkg::*;

  localparam int unsigned DIV = 16;
`ifdef BT_UART_TX_PARITY_EN
  localparam int unsigned FB = FRAME_BITS_8E1;
`else
  localparam int unsigned FB = FRAME_BITS_8N1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [FB-1:0] exp_q [$];

  always #5 clk = ~clk;

  bt_uart_tx #(
    .CLK_FREQ   (16),
    .BAUD       (1),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Line image of one frame, bit 0 first on the wire.
  function automatic logic [FB-1:0] frame_of(input logic [7:0] b);
    logic [FB-1:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w[i+1] = b[i];
`ifdef BT_UART_TX_PARITY_EN
    w[9] = ^b;
`endif
    w[FB-1] = 1'b1;
    return w;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    logic r;
    r = 1'b0;
    for (int n = 0; n < 2000 && !r; n++) begin
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = b;
      r        = tx_ready;
      @(posedge clk);
    end
    if (r) exp_q.push_back(frame_of(b));
    check("send_accepted", 32'(r), 32'd1);
  endtask

  task automatic drop_valid();
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 32'(busy === 1'b0 && exp_q.size() == 0), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic quiet_window(input string name, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check(name, 32'(bad), 32'd0);
  endtask

  // Line monitor: decodes each frame sample-by-sample and compares with the queue head.
  initial begin : monitor
    logic          b2b;
    logic          lvl;
    logic          unstable;
    logic          aborted;
    logic [FB-1:0] obs;
    logic [FB-1:0] expw;
    b2b = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        b2b = 1'b0;
        continue;
      end
      if (b2b) begin
        check("b2b_no_gap", 32'(tx), 32'd0);
        b2b = 1'b0;
      end
      if (tx !== 1'b0) continue;
      if (exp_q.size() == 0) begin
        check("unexpected_start", 32'(exp_q.size()), 32'd1);
        for (int n = 0; n < int'(FB * DIV) && tx === 1'b0; n++) @(negedge clk);
        continue;
      end
      expw     = exp_q.pop_front();
      obs      = '0;
      unstable = 1'b0;
      aborted  = 1'b0;
      lvl      = 1'b0;
      for (int i = 0; i < int'(FB * DIV); i++) begin
        if (i > 0) @(negedge clk);
        if (rst_n !== 1'b1) begin
          aborted = 1'b1;
          break;
        end
        if (i % DIV == 0) begin
          lvl = tx;
          obs[i / DIV] = tx;
        end else if (tx !== lvl) begin
          unstable = 1'b1;
        end
      end
      if (!aborted) begin
        check("frame_bits", 32'(obs), 32'(expw));
        check("bit_width", 32'(unstable), 32'd0);
        b2b = (exp_q.size() != 0);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int         acc;
    int         gap;
    logic       r [6];
    logic [7:0] b;

    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_ready", 32'(tx_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte: start-bit edge and busy fall timing.
    send_byte(8'hA5);
    drop_valid();
    check("tx_high_at_accept", 32'(tx), 32'd1);
    @(negedge clk);
    check("tx_start_next_edge", 32'(tx), 32'd0);
    repeat (159) @(negedge clk);
    check("busy_last_stop_cycle", 32'(busy), 32'd1);
    @(negedge clk);
    check("busy_after_frame", 32'(busy), 32'd0);
    check("tx_idle_after_frame", 32'(tx), 32'd1);
    drain();

    // Back-to-back bytes.
    send_byte(8'h00);
    send_byte(8'hFF);
    drop_valid();
    drain();

    // Hold valid for six cycles: one popped at once, four stored, sixth refused.
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      b        = 8'($urandom);
      tx_valid = 1'b1;
      tx_data  = b;
      r[i]     = tx_ready;
      @(posedge clk);
      if (r[i]) begin
        exp_q.push_back(frame_of(b));
        acc++;
      end
    end
    drop_valid();
    check("hold_accepts", 32'(acc), 32'd5);
    check("ready_low_when_full", 32'(r[5]), 32'd0);
    repeat (155) @(negedge clk);
    check("ready_low_before_pop", 32'(tx_ready), 32'd0);
    @(negedge clk);
    check("ready_high_after_pop", 32'(tx_ready), 32'd1);
    drain();

    // Reset during data bit 3 with bytes still queued.
    send_byte(8'h3C);
    send_byte(8'hC3);
    send_byte(8'h5A);
    drop_valid();
    repeat (69) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midframe_reset_tx", 32'(tx), 32'd1);
    check("midframe_reset_busy", 32'(busy), 32'd0);
    check("midframe_reset_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    quiet_window("post_reset_quiet", 400);

    // Parity-sensitive patterns (odd and even popcount).
    send_byte(8'h07);
    send_byte(8'h03);
    drop_valid();
    drain();

    // Random traffic with random gaps, including continuous valid.
    for (int i = 0; i < 40; i++) begin
      send_byte(8'($urandom));
      gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 200));
      if (gap > 0) begin
        drop_valid();
        repeat (gap) @(negedge clk);
      end
    end
    drop_valid();
    drain();

    quiet_window("idle_1000", 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
